// File: rtl/drum_lod_pipe.sv
// Two-stage DRUM leading-one / segment extraction pipeline.
// Stage 1 captures the operand with its leading-one index. Stage 2 produces the
// truncated segment, its restoring shift and a zero flag. Both stages use a
// valid/ready handshake and stall together under backpressure.
module drum_lod_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned K     = 6,
   parameter int unsigned IDXW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDXW-1:0]  out_idx,
   output logic [K-1:0]     out_seg,
   output logic [IDXW-1:0]  out_shift,
   output logic             out_zero
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [IDXW-1:0]  s1_idx;
   logic             s2_valid;
   logic             s1_adv;
   logic [IDXW-1:0]  lod_idx;
   logic [K-1:0]     seg_d;
   logic [IDXW-1:0]  shift_d;
   logic             zero_d;
   logic [WIDTH-1:0] a_shr;

   // Handshake: stage 1 may move on whenever stage 2 is empty or draining.
   always_comb begin
      s1_adv    = !s2_valid || out_ready;
      in_ready  = !s1_valid || s1_adv;
      out_valid = s2_valid;
   end

   // Priority encoder: the highest set bit wins because it is visited last.
   always_comb begin
      lod_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (in_a[i]) begin
            lod_idx = IDXW'(i);
         end
      end
   end

   // Stage 1 register: operand and leading-one index.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_idx   <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a   <= in_a;
            s1_idx <= lod_idx;
         end
      end
   end

   // Segment extraction: small operands pass unmodified, larger ones are
   // truncated to K bits below the leading one with the LSB forced high.
   always_comb begin
      seg_d   = '0;
      shift_d = '0;
      a_shr   = '0;
      zero_d  = (s1_a == '0);
      if (!zero_d) begin
         if (s1_idx < IDXW'(K)) begin
            seg_d = s1_a[K-1:0];
         end else begin
            shift_d  = s1_idx - IDXW'(K - 1);
            a_shr    = s1_a >> shift_d;
            seg_d    = a_shr[K-1:0];
            seg_d[0] = 1'b1;
         end
      end
   end

   // Stage 2 register: result ports, held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         out_idx   <= '0;
         out_seg   <= '0;
         out_shift <= '0;
         out_zero  <= 1'b0;
      end else if (s1_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_idx   <= s1_idx;
            out_seg   <= seg_d;
            out_shift <= shift_d;
            out_zero  <= zero_d;
         end
      end
   end

endmodule

// File: tb/tb_drum_lod_pipe.sv
// Directed self-checking bench for drum_lod_pipe: default configuration plus an
// exhaustive WIDTH=8, K=3 instance.
module tb_drum_lod_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_idx;
   logic [5:0]  out_seg;
   logic [3:0]  out_shift;
   logic        out_zero;

   logic        v8_in_valid;
   logic        v8_in_ready;
   logic [7:0]  v8_in_a;
   logic        v8_out_valid;
   logic        v8_out_ready;
   logic [2:0]  v8_out_idx;
   logic [2:0]  v8_out_seg;
   logic [2:0]  v8_out_shift;
   logic        v8_out_zero;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [15:0] STREAM [16] = '{
      16'h0001, 16'hB3C5, 16'h0000, 16'h0020, 16'h0040, 16'h8000, 16'h003F, 16'hFFFF,
      16'h1234, 16'h0F00, 16'h0007, 16'h4001, 16'h00FF, 16'h2AAA, 16'h0100, 16'h7FFF
   };

   drum_lod_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_seg   (out_seg),
      .out_shift (out_shift),
      .out_zero  (out_zero)
   );

   drum_lod_pipe #(
      .WIDTH (8),
      .K     (3)
   ) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v8_in_valid),
      .in_ready  (v8_in_ready),
      .in_a      (v8_in_a),
      .out_valid (v8_out_valid),
      .out_ready (v8_out_ready),
      .out_idx   (v8_out_idx),
      .out_seg   (v8_out_seg),
      .out_shift (v8_out_shift),
      .out_zero  (v8_out_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack a result tuple into one word for compact comparison and printing.
   function automatic int pack(input int z, input int idx, input int seg, input int sh);
      return (z << 24) | (idx << 16) | (seg << 8) | sh;
   endfunction

   // Reference: scan down from the MSB, then truncate as DRUM defines it.
   function automatic int ref_calc(input logic [63:0] a, input int w, input int k);
      int idx = 0;
      int seg = 0;
      int sh  = 0;
      int z   = 1;
      for (int i = w - 1; i >= 0; i--) begin
         if (a[i]) begin
            idx = i;
            z   = 0;
            break;
         end
      end
      if (z == 0) begin
         if (idx < k) begin
            seg = int'(a & ((64'd1 << k) - 1));
         end else begin
            sh  = idx - k + 1;
            seg = int'((a >> sh) & ((64'd1 << k) - 1)) | 1;
         end
      end
      return pack(z, idx, seg, sh);
   endfunction

   function automatic int obs16();
      return pack(int'(out_zero), int'(out_idx), int'(out_seg), int'(out_shift));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_a      = 16'hFFFF;
      out_ready = 1'b1;
      step();
      step();
      n_checks++;
      if (out_valid !== 1'b0 || obs16() !== 0) begin
         n_errors++;
         $display("FAIL reset_state: out_valid=%b result=%h, required 0 and 0", out_valid, obs16());
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      step();
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
      end
      for (int c = 0; c < 3; c++) begin
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_no_accept: cycle %0d out_valid=%b, required 0", c, out_valid);
         end
         step();
      end
   endtask

   task automatic test_single(input logic [15:0] a, input int e_idx, input int e_seg,
                              input int e_sh, input int e_z);
      int exp_r;
      exp_r     = pack(e_z, e_idx, e_seg, e_sh);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = a;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL single_in_ready a=%h: in_ready=%b, required 1", a, in_ready);
      end
      step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL single_latency1 a=%h: out_valid=%b, required 0", a, out_valid);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL single_latency2 a=%h: out_valid=%b, required 1", a, out_valid);
      end
      n_checks++;
      if (obs16() !== exp_r) begin
         n_errors++;
         $display("FAIL single_result a=%h: got %h, required %h", a, obs16(), exp_r);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL single_once a=%h: out_valid=%b, required 0", a, out_valid);
      end
   endtask

   task automatic test_throughput();
      out_ready = 1'b1;
      for (int c = 0; c < 11; c++) begin
         if (c >= 2 && c < 10) begin
            n_checks++;
            if (out_valid !== 1'b1 || obs16() !== ref_calc(64'(STREAM[c-2]), 16, 6)) begin
               n_errors++;
               $display("FAIL throughput_out c=%0d: valid=%b got %h, required 1 and %h", c,
                        out_valid, obs16(), ref_calc(64'(STREAM[c-2]), 16, 6));
            end
         end else begin
            n_checks++;
            if (out_valid !== 1'b0) begin
               n_errors++;
               $display("FAIL throughput_idle c=%0d: out_valid=%b, required 0", c, out_valid);
            end
         end
         in_valid = (c < 8);
         in_a     = (c < 8) ? STREAM[c] : 16'h0;
         #1;
         if (c < 8) begin
            n_checks++;
            if (in_ready !== 1'b1) begin
               n_errors++;
               $display("FAIL throughput_ready c=%0d: in_ready=%b, required 1", c, in_ready);
            end
         end
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int q[$];
      int sent = 0;
      int recv = 0;
      int occ  = 0;
      int snap = 0;
      bit held = 1'b0;
      bit in_fire;
      bit out_fire;
      for (int c = 0; c < 300 && recv < 16; c++) begin
         if (held) begin
            n_checks++;
            if (out_valid !== 1'b1 || obs16() !== snap) begin
               n_errors++;
               $display("FAIL b2b_stall_hold c=%0d: valid=%b got %h, required 1 and %h", c,
                        out_valid, obs16(), snap);
            end
         end
         if (occ == 0) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
               n_errors++;
               $display("FAIL b2b_spurious c=%0d: out_valid=%b, required 0", c, out_valid);
            end
         end
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (sent < 16);
         in_a      = (sent < 16) ? STREAM[sent] : 16'h0;
         #1;
         n_checks++;
         if (in_ready !== !(occ == 2 && !out_ready)) begin
            n_errors++;
            $display("FAIL b2b_in_ready c=%0d: in_ready=%b, required %b (occ=%0d)", c, in_ready,
                     !(occ == 2 && !out_ready), occ);
         end
         out_fire = out_valid && out_ready;
         in_fire  = in_valid && in_ready;
         held     = out_valid && !out_ready;
         snap     = obs16();
         if (out_fire) begin
            n_checks++;
            if (q.size() == 0) begin
               n_errors++;
               $display("FAIL b2b_extra c=%0d: got %h, required no result", c, obs16());
            end else begin
               if (obs16() !== q[0]) begin
                  n_errors++;
                  $display("FAIL b2b_order c=%0d: got %h, required %h", c, obs16(), q[0]);
               end
               void'(q.pop_front());
            end
            recv++;
         end
         if (in_fire) begin
            q.push_back(ref_calc(64'(STREAM[sent]), 16, 6));
            sent++;
         end
         occ = occ + int'(in_fire) - int'(out_fire);
         step();
      end
      in_valid = 1'b0;
      n_checks++;
      if (recv !== 16 || q.size() !== 0) begin
         n_errors++;
         $display("FAIL b2b_count: received %0d pending %0d, required 16 and 0", recv, q.size());
      end
   endtask

   task automatic test_reset_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a      = 16'h1234;
      step();
      in_a = 16'h0F00;
      step();
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_out_valid: out_valid=%b, required 0", out_valid);
      end
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_stale c=%0d: out_valid=%b, required 0", c, out_valid);
         end
      end
   endtask

   task automatic test_sweep8();
      int q[$];
      int got;
      v8_out_ready = 1'b1;
      for (int c = 0; c < 258; c++) begin
         got = pack(int'(v8_out_zero), int'(v8_out_idx), int'(v8_out_seg), int'(v8_out_shift));
         if (v8_out_valid) begin
            n_checks++;
            if (q.size() == 0) begin
               n_errors++;
               $display("FAIL sweep8_extra c=%0d: got %h, required no result", c, got);
            end else begin
               if (got !== q[0]) begin
                  n_errors++;
                  $display("FAIL sweep8_result c=%0d: got %h, required %h", c, got, q[0]);
               end
               void'(q.pop_front());
            end
         end else if (c >= 2) begin
            n_checks++;
            n_errors++;
            $display("FAIL sweep8_missing c=%0d: out_valid=0, required 1", c);
         end
         v8_in_valid = (c < 256);
         v8_in_a     = 8'(c);
         if (c < 256) begin
            q.push_back(ref_calc(64'(c), 8, 3));
         end
         step();
      end
      v8_in_valid = 1'b0;
      n_checks++;
      if (q.size() !== 0) begin
         n_errors++;
         $display("FAIL sweep8_drain: pending %0d, required 0", q.size());
      end
   endtask

   initial begin
      rst          = 1'b1;
      in_valid     = 1'b0;
      in_a         = '0;
      out_ready    = 1'b0;
      v8_in_valid  = 1'b0;
      v8_in_a      = '0;
      v8_out_ready = 1'b1;
      test_reset();
      test_single(16'h0001, 0, 6'h01, 0, 0);
      test_single(16'hB3C5, 15, 6'h2D, 10, 0);
      test_single(16'h0000, 0, 6'h00, 0, 1);
      test_single(16'h0020, 5, 6'h20, 0, 0);
      test_single(16'h0040, 6, 6'h21, 1, 0);
      test_single(16'h8000, 15, 6'h21, 10, 0);
      test_single(16'h003F, 5, 6'h3F, 0, 0);
      test_single(16'hFFFF, 15, 6'h3F, 10, 0);
      test_throughput();
      test_back_to_back();
      test_reset_flush();
      test_sweep8();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
